icache_refill_unit: RTL

- Miss-side writer for the 8 KB, 2-way, 32 B-block icache. The icache fetch path is the reader; this block is the writer that fills it.
- Accepts one block miss from the icache and requests the block from L2.
- Collects two 16 B response beats in any order and forwards the critical 16 B beat to fetch early.
- Writes the assembled 32 B block, with its tag, into the selected set and way.

---
 rtl/icache_refill_unit_if.sv | 58 +++++
 rtl/icache_refill_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/icache_refill_unit_if.sv
// Handshake and data bundle between the icache, L2 and the refill unit.
// The master modport is the environment (icache fetch/miss logic plus L2);
// the slave modport is the refill unit itself.
interface icache_refill_unit_if #(
    parameter int unsigned PA_WIDTH                  = 34,
    parameter int unsigned ICACHE_BLOCK_OFFSET_WIDTH = 5,
    parameter int unsigned ICACHE_INDEX_WIDTH        = 7,
    parameter int unsigned ICACHE_TAG_WIDTH          = 22,
    parameter int unsigned ICACHE_FETCH_WIDTH        = 16,
    parameter int unsigned ICACHE_ASSOC              = 2
);
    localparam int unsigned BlkW  = PA_WIDTH - ICACHE_BLOCK_OFFSET_WIDTH;
    localparam int unsigned BeatW = ICACHE_FETCH_WIDTH * 8;
    localparam int unsigned WayW  = $clog2(ICACHE_ASSOC);

    // Miss request from the icache
    logic                          miss_valid;
    logic                          miss_ready;
    logic [BlkW-1:0]               miss_block_addr;
    logic                          miss_fetch_offset;
    logic [WayW-1:0]               miss_way;
    // Request and response channels to L2
    logic                          l2_req_valid;
    logic                          l2_req_ready;
    logic [BlkW-1:0]               l2_req_block_addr;
    logic                          l2_resp_valid;
    logic                          l2_resp_beat;
    logic [BeatW-1:0]              l2_resp_data;
    // Fetch redirect and critical-beat forward
    logic                          kill;
    logic                          fwd_valid;
    logic [BlkW-1:0]               fwd_block_addr;
    logic                          fwd_offset;
    logic [BeatW-1:0]              fwd_data;
    // Array write port
    logic                          fill_valid;
    logic [ICACHE_INDEX_WIDTH-1:0] fill_index;
    logic [WayW-1:0]               fill_way;
    logic [ICACHE_TAG_WIDTH-1:0]   fill_tag;
    logic [2*BeatW-1:0]            fill_data;
    logic                          busy;

    modport master (
        output miss_valid, miss_block_addr, miss_fetch_offset, miss_way,
        output l2_req_ready, l2_resp_valid, l2_resp_beat, l2_resp_data, kill,
        input  miss_ready, l2_req_valid, l2_req_block_addr,
        input  fwd_valid, fwd_block_addr, fwd_offset, fwd_data,
        input  fill_valid, fill_index, fill_way, fill_tag, fill_data, busy
    );

    modport slave (
        input  miss_valid, miss_block_addr, miss_fetch_offset, miss_way,
        input  l2_req_ready, l2_resp_valid, l2_resp_beat, l2_resp_data, kill,
        output miss_ready, l2_req_valid, l2_req_block_addr,
        output fwd_valid, fwd_block_addr, fwd_offset, fwd_data,
        output fill_valid, fill_index, fill_way, fill_tag, fill_data, busy
    );
endinterface

// File: rtl/icache_refill_unit.sv
// Icache refill unit: takes one block miss, requests the 32 B block from L2,
// gathers the two 16 B beats in either order, forwards the critical beat to
// fetch one cycle after it lands, then writes the whole block into the arrays.
module icache_refill_unit #(
    parameter int unsigned PA_WIDTH                  = 34,
    parameter int unsigned ICACHE_BLOCK_OFFSET_WIDTH = 5,
    parameter int unsigned ICACHE_INDEX_WIDTH        = 7,
    parameter int unsigned ICACHE_TAG_WIDTH          = 22,
    parameter int unsigned ICACHE_FETCH_WIDTH        = 16,
    parameter int unsigned ICACHE_ASSOC              = 2
) (
    input logic                CLK,
    input logic                RST,
    icache_refill_unit_if.slave refill_if
);
    localparam int unsigned BlkW  = PA_WIDTH - ICACHE_BLOCK_OFFSET_WIDTH;
    localparam int unsigned BeatW = ICACHE_FETCH_WIDTH * 8;
    localparam int unsigned WayW  = $clog2(ICACHE_ASSOC);
    localparam int unsigned IdxW  = ICACHE_INDEX_WIDTH;
    localparam int unsigned TagW  = ICACHE_TAG_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, RESP, WRITE} state_t;

    state_t            r_state;
    logic [BlkW-1:0]   r_addr;
    logic              r_offset;
    logic [WayW-1:0]   r_way;
    logic [BeatW-1:0]  r_buf0;
    logic [BeatW-1:0]  r_buf1;
    logic [1:0]        r_mask;
    logic              r_kill;
    logic              r_fwd_done;

    logic              r_miss_ready;
    logic              r_busy;
    logic              r_l2_req_valid;
    logic              r_fwd_valid;
    logic [BlkW-1:0]   r_fwd_block_addr;
    logic              r_fwd_offset;
    logic [BeatW-1:0]  r_fwd_data;
    logic              r_fill_valid;
    logic [IdxW-1:0]   r_fill_index;
    logic [TagW-1:0]   r_fill_tag;
    logic [WayW-1:0]   r_fill_way;
    logic [2*BeatW-1:0] r_fill_data;

    logic [BeatW-1:0]  w_buf0_next;
    logic [BeatW-1:0]  w_buf1_next;
    logic [1:0]        w_mask_next;
    logic              w_fwd_hit;

    // Beat capture and forward qualification; only consumed while in RESP
    always_comb begin
        w_buf0_next = r_buf0;
        w_buf1_next = r_buf1;
        w_mask_next = r_mask;
        w_fwd_hit   = 1'b0;
        if (refill_if.l2_resp_valid) begin
            if (refill_if.l2_resp_beat) begin
                w_buf1_next    = refill_if.l2_resp_data;
                w_mask_next[1] = 1'b1;
            end else begin
                w_buf0_next    = refill_if.l2_resp_data;
                w_mask_next[0] = 1'b1;
            end
            // A kill arriving with the critical beat still suppresses it
            w_fwd_hit = (refill_if.l2_resp_beat == r_offset) && !r_kill &&
                        !refill_if.kill && !r_fwd_done;
        end
    end

    // Refill FSM with all outputs registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state          <= IDLE;
            r_addr           <= '0;
            r_offset         <= 1'b0;
            r_way            <= '0;
            r_buf0           <= '0;
            r_buf1           <= '0;
            r_mask           <= 2'b00;
            r_kill           <= 1'b0;
            r_fwd_done       <= 1'b0;
            r_miss_ready     <= 1'b1;
            r_busy           <= 1'b0;
            r_l2_req_valid   <= 1'b0;
            r_fwd_valid      <= 1'b0;
            r_fwd_block_addr <= '0;
            r_fwd_offset     <= 1'b0;
            r_fwd_data       <= '0;
            r_fill_valid     <= 1'b0;
            r_fill_index     <= '0;
            r_fill_tag       <= '0;
            r_fill_way       <= '0;
            r_fill_data      <= '0;
        end else begin
            r_fwd_valid  <= 1'b0;
            r_fill_valid <= 1'b0;
            // Sticky kill: forward is suppressed but the request and fill proceed
            if (r_state != IDLE && refill_if.kill) begin
                r_kill <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (refill_if.miss_valid) begin
                        r_addr         <= refill_if.miss_block_addr;
                        r_offset       <= refill_if.miss_fetch_offset;
                        r_way          <= refill_if.miss_way;
                        r_mask         <= 2'b00;
                        r_kill         <= 1'b0;
                        r_fwd_done     <= 1'b0;
                        r_l2_req_valid <= 1'b1;
                        r_miss_ready   <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= REQ;
                    end
                end
                REQ: begin
                    if (refill_if.l2_req_ready) begin
                        r_l2_req_valid <= 1'b0;
                        r_state        <= RESP;
                    end
                end
                RESP: begin
                    r_buf0 <= w_buf0_next;
                    r_buf1 <= w_buf1_next;
                    r_mask <= w_mask_next;
                    if (w_fwd_hit) begin
                        r_fwd_valid      <= 1'b1;
                        r_fwd_done       <= 1'b1;
                        r_fwd_data       <= refill_if.l2_resp_data;
                        r_fwd_block_addr <= r_addr;
                        r_fwd_offset     <= r_offset;
                    end
                    // Move on in the same cycle the last beat lands
                    if (w_mask_next == 2'b11) begin
                        r_fill_valid <= 1'b1;
                        r_fill_index <= r_addr[IdxW-1:0];
                        r_fill_tag   <= r_addr[BlkW-1:IdxW];
                        r_fill_way   <= r_way;
                        r_fill_data  <= {w_buf1_next, w_buf0_next};
                        r_state      <= WRITE;
                    end
                end
                WRITE: begin
                    r_miss_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign refill_if.miss_ready        = r_miss_ready;
    assign refill_if.busy              = r_busy;
    assign refill_if.l2_req_valid      = r_l2_req_valid;
    assign refill_if.l2_req_block_addr = r_addr;
    assign refill_if.fwd_valid         = r_fwd_valid;
    assign refill_if.fwd_block_addr    = r_fwd_block_addr;
    assign refill_if.fwd_offset        = r_fwd_offset;
    assign refill_if.fwd_data          = r_fwd_data;
    assign refill_if.fill_valid        = r_fill_valid;
    assign refill_if.fill_index        = r_fill_index;
    assign refill_if.fill_tag          = r_fill_tag;
    assign refill_if.fill_way          = r_fill_way;
    assign refill_if.fill_data         = r_fill_data;
endmodule
